gshare_predictor: RTL and testbench
===================================

Name: gshare_predictor

Overview:
- Global-history (gshare) direction predictor that answers the datapath's branch-prediction interface.
- Fetch side: gives a taken/not-taken prediction and a PHT index for the current fetch PC.
- Memory side: takes the resolved outcome of the branch in M, trains the pattern history table (PHT), detects mispredictions, and drives the PC redirect and the D/E/M pipeline flushes.
- Keeps a speculative global history register (GHR) and an architectural GHR, with recovery on mispredict.

Parameters:
- IDX_W, 8, PHT index width; the PHT holds 2^IDX_W two-bit counters.
- HIST_W, 8, GHR width; must satisfy 1 <= HIST_W <= IDX_W.
- STAT_W, 32, width of the performance counters.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- pc_f  in  32  fetch-stage PC.
- pred_taken_f  out  1  prediction for pc_f (combinational).
- pred_idx_f  out  IDX_W  PHT index used for pc_f; the datapath pipes it to M.
- en_d  in  1  D stage advancing (~stallD).
- branch_d  in  1  a branch is present in D.
- pred_d  in  1  the prediction carried with that branch.
- upd_valid_m  in  1  a branch is present in M (branchM).
- upd_idx_m  in  IDX_W  piped pred_idx_f of the branch in M.
- upd_taken_m  in  1  actual direction.
- upd_pred_m  in  1  predicted direction.
- upd_fix_pc_m  in  32  correct PC if the prediction was wrong.
- mispredict  out  1  misprediction detected in M (combinational).
- redirect_pc  out  32  equals upd_fix_pc_m; valid only while mispredict=1.
- flush_d  out  1  clear the F->D register.
- flush_e  out  1  clear the D->E register.
- flush_m  out  1  clear the E->M register.
- branch_cnt  out  STAT_W  number of resolved branches.
- miss_cnt  out  STAT_W  number of mispredicted branches.

Behaviour:
- Reset (synchronous, rst=1 sampled at clk):
  - every PHT entry = 2'b01 (weakly not-taken);
  - ghr_spec = ghr_arch = 0;
  - branch_cnt = miss_cnt = 0.
  - Outputs after reset: pred_taken_f=0 for any PC; mispredict and all flushes are 0 while upd_valid_m=0; redirect_pc follows upd_fix_pc_m.
  - Reset wins over every simultaneous update.
- Lookup (combinational, zero latency):
  - pred_idx_f = pc_f[IDX_W+1:2] XOR zero_extend(ghr_spec).
  - pred_taken_f = PHT[pred_idx_f][1].
  - A read returns the pre-edge PHT value. There is no bypass from a same-cycle update, even when the index matches.
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Training: when upd_valid_m=1, PHT[upd_idx_m] saturates toward upd_taken_m.
  - Taken: 11 stays 11; otherwise +1.
  - Not taken: 00 stays 00; otherwise -1.
  - Training happens on every resolved branch, correct or not.
- Misprediction:
  - mispredict = upd_valid_m & (upd_taken_m != upd_pred_m).
  - flush_d = flush_e = flush_m = mispredict, in the same cycle.
- Architectural GHR: when upd_valid_m=1, ghr_arch <= {ghr_arch[HIST_W-2:0], upd_taken_m}. For HIST_W=1, ghr_arch <= upd_taken_m.
- Speculative GHR, priority highest first:
  1. mispredict: ghr_spec <= {ghr_arch[HIST_W-2:0], upd_taken_m}, i.e. the same value ghr_arch takes. Any same-cycle D shift is discarded, because that D instruction is being flushed.
  2. en_d & branch_d: ghr_spec <= {ghr_spec[HIST_W-2:0], pred_d}.
  3. otherwise: hold.
- Correct-prediction M update and a D shift in the same cycle: both GHRs update independently.
- Statistics:
  - branch_cnt increments on each upd_valid_m; miss_cnt increments on each mispredict.
  - Both saturate at all-ones and never wrap.
- Stall: with en_d=0, the D branch does not shift ghr_spec, regardless of how many cycles D holds.
- Reset mid-operation: PHT, GHRs and counters clear on that edge. Outputs are the combinational functions of the cleared state from the next cycle on.

Decomposition:
- Shared package bp_pkg:
  - counter encoding constants SNT/WNT/WT/ST;
  - the PHT reset value;
  - function sat_update(cnt, taken) -> cnt.
- One sub-module, pht_counter_array:
  - 2^IDX_W x 2-bit;
  - one asynchronous read port, one synchronous write port;
  - synchronous clear on rst.
  - GHR and statistics logic stay in the top module.

Test Plan:
- Reset then lookup: rst for 1 cycle, then pc_f=0x0040_0010 -> pred_taken_f=0, pred_idx_f=0x04, mispredict=0, branch_cnt=miss_cnt=0.
- Training saturation: 3 updates of idx 0x04 with taken=1, pred=1 -> counter 01->10->11->11. With ghr_spec=0, pc_f=0x0040_0010 predicts 1. branch_cnt=3, miss_cnt=0, no flush.
- Mispredict recovery:
  - setup: ghr_arch=0x05, ghr_spec=0x2B;
  - stimulus: upd_valid_m=1, pred=1, taken=0, fix_pc=0x0040_0100, with en_d=1 and branch_d=1 in the same cycle;
  - response: mispredict and flush_d/e/m=1 and redirect_pc=0x0040_0100 that cycle; next cycle ghr_spec=ghr_arch=0x0A.
- Stall hold: en_d=0, branch_d=1, pred_d=1 for 4 cycles -> ghr_spec unchanged. en_d=1 for 1 cycle -> ghr_spec shifts by exactly one, LSB=1.
- Same-index read/write: pc_f indexes entry 0x04 = 01 while upd_idx_m=0x04 trains taken -> pred_taken_f=0 that cycle and 1 the next cycle.
- Counter saturation: preload miss_cnt=0xFFFF_FFFE (force), apply 3 mispredicts -> miss_cnt=0xFFFF_FFFF and holds.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared definitions for the gshare direction predictor: 2-bit counter encoding
// and the saturating counter update used when training the pattern history table.
package bp_pkg;

    localparam logic [1:0] SNT     = 2'b00;
    localparam logic [1:0] WNT     = 2'b01;
    localparam logic [1:0] WT      = 2'b10;
    localparam logic [1:0] ST      = 2'b11;
    localparam logic [1:0] PHT_RST = WNT;

    function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
        logic [1:0] r;
        r = cnt;
        if (taken) begin
            if (cnt != ST) r = cnt + 2'd1;
        end else begin
            if (cnt != SNT) r = cnt - 2'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/pht_counter_array.sv
// Pattern history table: 2^IDX_W two-bit counters, async read, sync saturating-train write.
// Reads see the pre-edge value; a same-index write lands on the next edge with no bypass.
module pht_counter_array
    import bp_pkg::*;
#(
    parameter int IDX_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] i_rd_idx,
    output logic [1:0]       o_rd_cnt,
    input  logic             i_wr_en,
    input  logic [IDX_W-1:0] i_wr_idx,
    input  logic             i_wr_taken
);

    localparam int DEPTH = 1 << IDX_W;

    logic [1:0] r_cnt [DEPTH];

    assign o_rd_cnt = r_cnt[i_rd_idx];

    // Write port trains in place so the top never needs a second read port.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_cnt[i] <= PHT_RST;
            end
        end else if (i_wr_en) begin
            r_cnt[i_wr_idx] <= sat_update(r_cnt[i_wr_idx], i_wr_taken);
        end
    end

endmodule

// File: rtl/gshare_predictor.sv
// Gshare predictor: combinational fetch lookup, M-stage training, mispredict redirect/flush,
// speculative and architectural global history with recovery, saturating statistics.
module gshare_predictor
    import bp_pkg::*;
#(
    parameter int IDX_W  = 8,
    parameter int HIST_W = 8,
    parameter int STAT_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       pc_f,
    output logic              pred_taken_f,
    output logic [IDX_W-1:0]  pred_idx_f,
    input  logic              en_d,
    input  logic              branch_d,
    input  logic              pred_d,
    input  logic              upd_valid_m,
    input  logic [IDX_W-1:0]  upd_idx_m,
    input  logic              upd_taken_m,
    input  logic              upd_pred_m,
    input  logic [31:0]       upd_fix_pc_m,
    output logic              mispredict,
    output logic [31:0]       redirect_pc,
    output logic              flush_d,
    output logic              flush_e,
    output logic              flush_m,
    output logic [STAT_W-1:0] branch_cnt,
    output logic [STAT_W-1:0] miss_cnt
);

    logic [HIST_W-1:0] r_ghr_spec;
    logic [HIST_W-1:0] r_ghr_arch;
    logic [STAT_W-1:0] r_branch_cnt;
    logic [STAT_W-1:0] r_miss_cnt;

    logic [HIST_W-1:0] w_arch_next;
    logic [HIST_W-1:0] w_spec_shift;
    logic [IDX_W-1:0]  w_ghr_ext;
    logic [1:0]        w_rd_cnt;
    logic              w_unused;

    generate
        if (HIST_W == 1) begin : g_hist1
            assign w_arch_next  = upd_taken_m;
            assign w_spec_shift = pred_d;
        end else begin : g_histn
            assign w_arch_next  = {r_ghr_arch[HIST_W-2:0], upd_taken_m};
            assign w_spec_shift = {r_ghr_spec[HIST_W-2:0], pred_d};
        end
    endgenerate

    always_comb begin
        w_ghr_ext = '0;
        w_ghr_ext[HIST_W-1:0] = r_ghr_spec;
    end

    assign pred_idx_f   = pc_f[IDX_W+1:2] ^ w_ghr_ext;
    assign pred_taken_f = w_rd_cnt[1];
    assign w_unused     = ^{pc_f[31:IDX_W+2], pc_f[1:0]};

    assign mispredict  = upd_valid_m & (upd_taken_m != upd_pred_m);
    assign redirect_pc = upd_fix_pc_m;
    assign flush_d     = mispredict;
    assign flush_e     = mispredict;
    assign flush_m     = mispredict;
    assign branch_cnt  = r_branch_cnt;
    assign miss_cnt    = r_miss_cnt;

    pht_counter_array #(.IDX_W(IDX_W)) u_pht (
        .clk        (clk),
        .rst        (rst),
        .i_rd_idx   (pred_idx_f),
        .o_rd_cnt   (w_rd_cnt),
        .i_wr_en    (upd_valid_m),
        .i_wr_idx   (upd_idx_m),
        .i_wr_taken (upd_taken_m)
    );

    // A mispredict flushes the D branch, so its history shift is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ghr_spec   <= '0;
            r_ghr_arch   <= '0;
            r_branch_cnt <= '0;
            r_miss_cnt   <= '0;
        end else begin
            if (upd_valid_m) begin
                r_ghr_arch <= w_arch_next;
            end
            if (mispredict) begin
                r_ghr_spec <= w_arch_next;
            end else if (en_d && branch_d) begin
                r_ghr_spec <= w_spec_shift;
            end
            if (upd_valid_m && (r_branch_cnt != '1)) begin
                r_branch_cnt <= r_branch_cnt + STAT_W'(1);
            end
            if (mispredict && (r_miss_cnt != '1)) begin
                r_miss_cnt <= r_miss_cnt + STAT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_gshare_predictor.sv
// Scoreboard bench for gshare_predictor: a behavioural model predicts every cycle's outputs.
module tb_gshare_predictor;

    localparam int IDX_W  = 8;
    localparam int HIST_W = 8;
    localparam int STAT_W = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [31:0]       pc_f;
    logic              pred_taken_f;
    logic [IDX_W-1:0]  pred_idx_f;
    logic              en_d, branch_d, pred_d;
    logic              upd_valid_m;
    logic [IDX_W-1:0]  upd_idx_m;
    logic              upd_taken_m, upd_pred_m;
    logic [31:0]       upd_fix_pc_m;
    logic              mispredict;
    logic [31:0]       redirect_pc;
    logic              flush_d, flush_e, flush_m;
    logic [STAT_W-1:0] branch_cnt, miss_cnt;

    gshare_predictor #(.IDX_W(IDX_W), .HIST_W(HIST_W), .STAT_W(STAT_W)) dut (
        .clk(clk), .rst(rst), .pc_f(pc_f), .pred_taken_f(pred_taken_f), .pred_idx_f(pred_idx_f),
        .en_d(en_d), .branch_d(branch_d), .pred_d(pred_d), .upd_valid_m(upd_valid_m),
        .upd_idx_m(upd_idx_m), .upd_taken_m(upd_taken_m), .upd_pred_m(upd_pred_m),
        .upd_fix_pc_m(upd_fix_pc_m), .mispredict(mispredict), .redirect_pc(redirect_pc),
        .flush_d(flush_d), .flush_e(flush_e), .flush_m(flush_m),
        .branch_cnt(branch_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        pt;
        logic [7:0]  idx;
        logic        mis;
        logic [2:0]  fl;
        logic [31:0] rpc;
        logic [7:0]  bc;
        logic [7:0]  mc;
    } exp_t;

    exp_t        exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    logic [1:0]  m_pht [256];
    logic [7:0]  m_spec, m_arch, m_bc, m_mc;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic [31:0] pc, input logic en, input logic br,
                         input logic pd, input logic uv, input logic [7:0] ui, input logic ut,
                         input logic up, input logic [31:0] fix);
        rst = r; pc_f = pc; en_d = en; branch_d = br; pred_d = pd;
        upd_valid_m = uv; upd_idx_m = ui; upd_taken_m = ut; upd_pred_m = up; upd_fix_pc_m = fix;
    endtask

    function automatic logic [1:0] m_sat(input logic [1:0] c, input logic t);
        if (t) return (c == 2'b11) ? c : c + 2'd1;
        return (c == 2'b00) ? c : c - 2'd1;
    endfunction

    // Predict this cycle's outputs, compare, clock once, then advance the model.
    task automatic tick(input bit cmp);
        exp_t e;
        logic mis;
        logic [7:0] arch_n;
        #1;
        mis = upd_valid_m & (upd_taken_m != upd_pred_m);
        if (cmp) begin
            e.idx = pc_f[9:2] ^ m_spec;
            e.pt  = m_pht[e.idx][1];
            e.mis = mis;
            e.fl  = {3{mis}};
            e.rpc = upd_fix_pc_m;
            e.bc  = m_bc;
            e.mc  = m_mc;
            exp_q.push_back(e);
        end
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("pred_taken", 32'(pred_taken_f), 32'(e.pt));
            chk("pred_idx",   32'(pred_idx_f),   32'(e.idx));
            chk("mispredict", 32'(mispredict),   32'(e.mis));
            chk("flush",      32'({flush_d, flush_e, flush_m}), 32'(e.fl));
            if (e.mis) chk("redirect", redirect_pc, e.rpc);
            chk("branch_cnt", 32'(branch_cnt),   32'(e.bc));
            chk("miss_cnt",   32'(miss_cnt),     32'(e.mc));
        end
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 256; i++) m_pht[i] = 2'b01;
            m_spec = 0; m_arch = 0; m_bc = 0; m_mc = 0;
        end else begin
            arch_n = {m_arch[6:0], upd_taken_m};
            if (upd_valid_m) begin
                m_pht[upd_idx_m] = m_sat(m_pht[upd_idx_m], upd_taken_m);
                m_arch = arch_n;
                if (m_bc != 8'hFF) m_bc++;
            end
            if (mis && m_mc != 8'hFF) m_mc++;
            if (mis) m_spec = arch_n;
            else if (en_d && branch_d) m_spec = {m_spec[6:0], pred_d};
        end
        @(negedge clk);
    endtask

    localparam logic [31:0] PC0 = 32'h0040_0010;

    initial begin
        logic [7:0] a_bits, s_bits;
        a_bits = 8'h05;
        s_bits = 8'h2B;
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        tick(0);

        // Reset then lookup
        drive(0, PC0, 0, 0, 0, 0, 0, 0, 0, 32'h1234_5678);
        #1;
        chk("rst_pred", 32'(pred_taken_f), 0);
        chk("rst_idx",  32'(pred_idx_f), 32'h04);
        chk("rst_mis",  32'(mispredict), 0);
        chk("rst_bcnt", 32'(branch_cnt), 0);
        chk("rst_mcnt", 32'(miss_cnt), 0);
        tick(1);

        // Training with same-index lookup: no bypass, then new value next cycle
        for (int k = 0; k < 3; k++) begin
            drive(0, PC0, 0, 0, 0, 1, 8'h04, 1, 1, 0);
            #1;
            chk("same_idx_pred", 32'(pred_taken_f), (k == 0) ? 32'd0 : 32'd1);
            tick(1);
        end
        drive(0, PC0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("train_pred", 32'(pred_taken_f), 1);
        chk("train_bcnt", 32'(branch_cnt), 3);
        chk("train_mcnt", 32'(miss_cnt), 0);
        chk("train_flush", 32'(flush_d), 0);
        tick(1);

        // Build ghr_arch=0x05 and ghr_spec=0x2B together with correct predictions
        for (int k = 7; k >= 0; k--) begin
            drive(0, 0, 1, 1, s_bits[k], 1, 8'(8'h80 + k), a_bits[k], a_bits[k], 0);
            tick(1);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("setup_spec", 32'(pred_idx_f), 32'h2B);
        tick(1);

        // Mispredict with simultaneous D shift
        drive(0, 0, 1, 1, 1, 1, 8'h90, 0, 1, 32'h0040_0100);
        #1;
        chk("mis_flag",  32'(mispredict), 1);
        chk("mis_flush", 32'({flush_d, flush_e, flush_m}), 32'h7);
        chk("mis_redir", redirect_pc, 32'h0040_0100);
        tick(1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("recover_spec", 32'(pred_idx_f), 32'h0A);
        tick(1);

        // Stall hold then one advance
        for (int k = 0; k < 4; k++) begin
            drive(0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
            tick(1);
        end
        #1;
        chk("stall_hold", 32'(pred_idx_f), 32'h0A);
        drive(0, 0, 1, 1, 1, 0, 0, 0, 0, 0);
        tick(1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("stall_shift", 32'(pred_idx_f), 32'h15);
        tick(1);

        // Random traffic
        for (int k = 0; k < 300; k++) begin
            drive(0, $urandom, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                  8'($urandom), 1'($urandom), 1'($urandom), $urandom);
            tick(1);
        end

        // Drive both statistics counters into saturation
        for (int k = 0; k < 260; k++) begin
            logic t;
            t = 1'($urandom);
            drive(0, $urandom, 1'($urandom), 1, 1'($urandom), 1, 8'($urandom), t, ~t, $urandom);
            tick(1);
        end
        drive(0, PC0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("sat_mcnt", 32'(miss_cnt), 32'hFF);
        chk("sat_bcnt", 32'(branch_cnt), 32'hFF);
        tick(1);

        // Reset wins over a simultaneous mispredicting update
        drive(1, PC0, 1, 1, 1, 1, 8'h04, 1, 0, 32'hDEAD_BEE0);
        tick(1);
        drive(0, PC0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("mid_rst_pred", 32'(pred_taken_f), 0);
        chk("mid_rst_idx",  32'(pred_idx_f), 32'h04);
        chk("mid_rst_bcnt", 32'(branch_cnt), 0);
        chk("mid_rst_mcnt", 32'(miss_cnt), 0);
        tick(1);

        chk("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
